// File: rtl/cpu_pkg.sv
// Shared opcode constants, ALU-class helper and the packed control word for the teaching CPU.
// No logic of its own; consumed by the controller and anything decoding its control word.
// No flow control: types and constants only.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Control word, MSB first in the order the datapath documentation lists the strobes.
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes whose execute phases read memory and finish by loading the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller.sv
// Instruction-cycle controller: decodes opcode, phase and zero into the nine datapath strobes.
// Latency: purely combinational, zero cycles; rst forces every strobe low immediately.
// Backpressure: none; the external phase counter owns sequencing and may wrap 7->0 freely.
module controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [2:0] phase,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);

  ctrl_t ctrl;
  logic  aluop;

  assign aluop = is_aluop(opcode);

  // Per-phase decode; every strobe defaults low so unlisted (opcode, phase) pairs stay 0.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (phase)
        // Fetch: address memory with the PC, read it, then capture into the IR.
        3'd0: begin
          ctrl.sel = 1'b1;
        end
        3'd1: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        // Step past the fetched instruction; HLT also stops the machine here.
        3'd4: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == OP_HLT);
        end
        // ALU-class ops start reading their operand; everything else idles.
        3'd5: begin
          ctrl.rd = aluop;
        end
        // ALU ops keep reading; SKZ skips on zero; JMP loads PC; STO drives the accumulator.
        3'd6: begin
          ctrl.rd     = aluop;
          ctrl.inc_pc = (opcode == OP_SKZ) && zero;
          ctrl.ld_pc  = (opcode == OP_JMP);
          ctrl.data_e = (opcode == OP_STO);
        end
        // Commit: ALU ops load the accumulator, STO writes memory, JMP holds the PC load.
        // SKZ and HLT stay idle here regardless of zero.
        3'd7: begin
          ctrl.rd     = aluop;
          ctrl.ld_ac  = aluop;
          ctrl.data_e = (opcode == OP_STO);
          ctrl.wr     = (opcode == OP_STO);
          ctrl.ld_pc  = (opcode == OP_JMP);
        end
      endcase
    end
  end

  assign {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = ctrl;

  // Memory and accumulator must never drive the data bus together, and memory is never
  // read and written at once.
  a_no_bus_fight: assert property (@(posedge clk) disable iff (rst) !(ctrl.rd && ctrl.data_e));
  a_no_rd_wr:     assert property (@(posedge clk) disable iff (rst) !(ctrl.rd && ctrl.wr));

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed literal cases plus randomized sweep vs model.
// Inputs change 1ns after posedge; a compare process checks every negedge.
// No flow control in the DUT; the bench never waits on a DUT event.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic [2:0] phase;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .phase  (phase),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  always #5 clk = ~clk;

  wire [8:0] dut_w = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  // Reference: each strobe written as its own rule over (phase, opcode, zero).
  function automatic logic [8:0] model(input logic r, input int op, input int ph, input logic z);
    bit alu, e_sel, e_rd, e_ir, e_inc, e_hlt, e_ldpc, e_de, e_ldac, e_wr;
    alu    = (op >= 2) && (op <= 5);
    e_sel  = (ph < 4);
    e_rd   = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    e_ir   = (ph == 2) || (ph == 3);
    e_inc  = (ph == 4) || (op == 1 && z && ph == 6);
    e_hlt  = (ph == 4) && (op == 0);
    e_ldpc = (op == 7) && (ph >= 6);
    e_de   = (op == 6) && (ph >= 6);
    e_ldac = alu && (ph == 7);
    e_wr   = (op == 6) && (ph == 7);
    if (r) return 9'b0;
    return {e_sel, e_rd, e_ir, e_inc, e_hlt, e_ldpc, e_de, e_ldac, e_wr};
  endfunction

  task automatic chk(input string name, input logic [8:0] exp);
    n_cmp++;
    if (dut_w !== exp) begin
      n_bad++;
      $display("FAIL %s: rst=%0b op=%0d ph=%0d zero=%0b got %b expected %b",
               name, rst, opcode, phase, zero, dut_w, exp);
    end
  endtask

  task automatic drive(input logic r, input int op, input int ph, input logic z);
    @(posedge clk);
    #1;
    rst    = r;
    opcode = op[2:0];
    phase  = ph[2:0];
    zero   = z;
    #1;
  endtask

  // Compare process: model vs DUT on every cycle once stimulus is live.
  always @(negedge clk) begin
    if (cmp_en) chk("model", model(rst, int'(opcode), int'(phase), zero));
  end

  localparam logic [8:0] W_SEL  = 9'b100000000;
  localparam logic [8:0] W_RD   = 9'b010000000;
  localparam logic [8:0] W_IR   = 9'b001000000;
  localparam logic [8:0] W_INC  = 9'b000100000;
  localparam logic [8:0] W_HLT  = 9'b000010000;
  localparam logic [8:0] W_LDPC = 9'b000001000;
  localparam logic [8:0] W_DE   = 9'b000000100;
  localparam logic [8:0] W_LDAC = 9'b000000010;
  localparam logic [8:0] W_WR   = 9'b000000001;

  initial begin
    logic [8:0] fetch_exp [4];
    logic [8:0] alu_exp   [3];
    logic [8:0] sto_exp   [3];
    logic [8:0] jmp_exp   [3];
    fetch_exp = '{W_SEL, W_SEL | W_RD, W_SEL | W_RD | W_IR, W_SEL | W_RD | W_IR};
    alu_exp   = '{W_RD, W_RD, W_RD | W_LDAC};
    sto_exp   = '{9'b0, W_DE, W_DE | W_WR};
    jmp_exp   = '{9'b0, W_LDPC, W_LDPC};

    rst = 1'b1; opcode = 3'd2; phase = 3'd7; zero = 1'b0;
    #2;
    cmp_en = 1'b1;

    // Reset overrides decode, then ADD phase 7 decodes as soon as rst drops.
    drive(1'b1, 2, 7, 1'b0); chk("reset_add_p7", 9'b0);
    drive(1'b0, 2, 7, 1'b0); chk("post_reset_add_p7", W_RD | W_LDAC);

    // Fetch sweep.
    for (int op = 0; op < 8; op++)
      for (int ph = 0; ph < 4; ph++) begin
        drive(1'b0, op, ph, op[0]);
        chk("fetch", fetch_exp[ph]);
      end

    // Phase 4.
    for (int op = 0; op < 8; op++) begin
      drive(1'b0, op, 4, 1'b1);
      chk("phase4", (op == 0) ? (W_INC | W_HLT) : W_INC);
    end

    // SKZ.
    for (int ph = 5; ph < 8; ph++) begin
      drive(1'b0, 1, ph, 1'b0);
      chk("skz_z0", 9'b0);
    end
    drive(1'b0, 1, 6, 1'b1); chk("skz_z1_p6", W_INC);
    drive(1'b0, 1, 7, 1'b1); chk("skz_z1_p7", 9'b0);
    drive(1'b0, 1, 5, 1'b1); chk("skz_z1_p5", 9'b0);

    // ALU-class, STO, JMP execute phases.
    for (int op = 2; op < 6; op++)
      for (int ph = 5; ph < 8; ph++) begin
        drive(1'b0, op, ph, ph[0]);
        chk("aluop", alu_exp[ph-5]);
      end
    for (int ph = 5; ph < 8; ph++) begin
      drive(1'b0, 6, ph, 1'b1); chk("sto", sto_exp[ph-5]);
      drive(1'b0, 7, ph, 1'b1); chk("jmp", jmp_exp[ph-5]);
    end
    drive(1'b0, 0, 7, 1'b1); chk("hlt_p7", 9'b0);
    drive(1'b0, 0, 6, 1'b1); chk("hlt_p6", 9'b0);

    // Randomized inputs, including occasional reset pulses.
    for (int i = 0; i < 2000; i++)
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1);

    // Phase-counter style sequences with wrap, per opcode and zero value.
    for (int op = 0; op < 8; op++)
      for (int z = 0; z < 2; z++)
        for (int k = 0; k < 10; k++)
          drive(1'b0, op, k % 8, z[0]);

    @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
